// File: rtl/bgpu_dispatch_pkg.sv
// Shared types for the kernel-level warp dispatcher: FSM states and the latched launch record.
package bgpu_dispatch_pkg;

   localparam int unsigned LaunchPcWidth   = 16;
   localparam int unsigned LaunchWarpWidth = 16;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DISPATCH = 2'd1,
      ST_DRAIN    = 2'd2,
      ST_DONE     = 2'd3
   } dispatch_state_e;

   typedef struct packed {
      logic [LaunchPcWidth-1:0]   pc;
      logic [LaunchWarpWidth-1:0] num_warps;
   } launch_t;

endpackage

// File: rtl/rr_credit_arbiter.sv
// Round-robin selection among CUs that still have credit; the grant is locked while the
// selected CU stalls so a credit returning on another CU cannot steal an offered warp.
module rr_credit_arbiter #(
   parameter int unsigned NumPorts = 4,
   parameter int unsigned IdxWidth = 2
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                en_i,
   input  logic [NumPorts-1:0] avail_i,
   input  logic                accept_i,
   output logic                grant_valid_o,
   output logic [NumPorts-1:0] grant_o,
   output logic [IdxWidth-1:0] grant_idx_o
);

   logic [IdxWidth-1:0] ptr_q, ptr_d;
   logic [IdxWidth-1:0] lock_idx_q, lock_idx_d;
   logic                lock_q, lock_d;
   logic                found_s;
   logic [IdxWidth-1:0] found_idx_s;

   // First available port at or after the pointer, wrapping once around.
   always_comb begin
      int cand;
      found_s     = 1'b0;
      found_idx_s = '0;
      for (int off = 0; off < int'(NumPorts); off++) begin
         cand = int'(ptr_q) + off;
         cand = (cand >= int'(NumPorts)) ? (cand - int'(NumPorts)) : cand;
         if (!found_s && avail_i[cand]) begin
            found_s     = 1'b1;
            found_idx_s = IdxWidth'(cand);
         end else begin
            found_s     = found_s;
         end
      end
   end

   // Grant, lock and pointer next-state.
   always_comb begin
      grant_valid_o = en_i && (lock_q || found_s);
      grant_idx_o   = lock_q ? lock_idx_q : found_idx_s;
      grant_o       = grant_valid_o ? (NumPorts'(1) << grant_idx_o) : '0;
      lock_d        = grant_valid_o && !accept_i;
      lock_idx_d    = grant_idx_o;
      if (grant_valid_o && accept_i) begin
         ptr_d = (grant_idx_o == IdxWidth'(NumPorts - 1)) ? '0 : (grant_idx_o + IdxWidth'(1));
      end else begin
         ptr_d = ptr_q;
      end
   end

   // Pointer and lock registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q      <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
      end else begin
         ptr_q      <= ptr_d;
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
      end
   end

endmodule

// File: rtl/warp_launch_dispatcher_chk.sv
// Protocol checks for the dispatcher: stray completion pulses and start-channel stability.
module warp_launch_dispatcher_chk #(
   parameter int unsigned NumComputeUnits = 4,
   parameter int unsigned PcWidth         = 16,
   parameter int unsigned KernelWarpWidth = 16
) (
   input logic                       clk_i,
   input logic                       rst_i,
   input logic                       idle_i,
   input logic [NumComputeUnits-1:0] done_i,
   input logic [NumComputeUnits-1:0] sat_i,
   input logic [NumComputeUnits-1:0] valid_i,
   input logic [NumComputeUnits-1:0] ready_i,
   input logic [PcWidth-1:0]         pc_i,
   input logic [KernelWarpWidth-1:0] gwid_i
);

   a_done_in_idle: assert property (@(posedge clk_i) disable iff (rst_i)
      !(idle_i && (done_i != '0)))
      else $error("warp done pulse received while idle");

   a_credit_sat: assert property (@(posedge clk_i) disable iff (rst_i)
      (done_i & sat_i) == '0)
      else $error("warp done pulse on a CU with full credit");

   a_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
      $onehot0(valid_i))
      else $error("more than one CU start request");

   a_hold: assert property (@(posedge clk_i) disable iff (rst_i)
      ((valid_i != '0) && ((valid_i & ready_i) == '0)) |=>
      ((valid_i == $past(valid_i)) && (pc_i == $past(pc_i)) && (gwid_i == $past(gwid_i))))
      else $error("stalled start request changed");

endmodule

// File: rtl/warp_launch_dispatcher.sv
// Kernel launch dispatcher: hands warps to CUs round-robin under per-CU credit, tracks retirement.
// Optional busy-cycle counter perf_cycles_o when BGPU_DISPATCH_PERF_EN is defined.
module warp_launch_dispatcher
   import bgpu_dispatch_pkg::*;
#(
   parameter int unsigned NumComputeUnits = 4,
   parameter int unsigned NumWarps        = 8,
   parameter int unsigned PcWidth         = LaunchPcWidth,
   parameter int unsigned KernelWarpWidth = LaunchWarpWidth
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       launch_valid_i,
   output logic                       launch_ready_o,
   input  logic [PcWidth-1:0]         launch_pc_i,
   input  logic [KernelWarpWidth-1:0] launch_num_warps_i,
   output logic                       busy_o,
   output logic                       done_o,
   output logic [NumComputeUnits-1:0] cu_start_valid_o,
   input  logic [NumComputeUnits-1:0] cu_start_ready_i,
   output logic [PcWidth-1:0]         cu_start_pc_o,
   output logic [KernelWarpWidth-1:0] cu_start_gwid_o,
   input  logic [NumComputeUnits-1:0] cu_warp_done_i
`ifdef BGPU_DISPATCH_PERF_EN
   ,
   output logic [31:0]                perf_cycles_o
`endif
);

   localparam int unsigned CuIdxWidth  = (NumComputeUnits > 1) ? $clog2(NumComputeUnits) : 1;
   localparam int unsigned CreditWidth = $clog2(NumWarps + 1);

   dispatch_state_e            state_q, state_d;
   launch_t                    launch_q, launch_d;
   logic [KernelWarpWidth-1:0] issued_q, issued_d;
   logic [KernelWarpWidth-1:0] retired_q, retired_d;
   logic [CreditWidth-1:0]     credit_q [NumComputeUnits];
   logic [CreditWidth-1:0]     credit_d [NumComputeUnits];

   logic [NumComputeUnits-1:0] avail_s, credit_inc_s, credit_dec_s, sat_s, done_eff_s, grant_s;
   logic [CuIdxWidth-1:0]      grant_idx_s;
   logic                       grant_valid_s, hs_s, launch_hs_s;
   logic [KernelWarpWidth-1:0] retire_cnt_s, issued_inc_s, retired_inc_s, num_warps_s;

   assign launch_ready_o   = (state_q == ST_IDLE);
   assign busy_o           = (state_q != ST_IDLE);
   assign done_o           = (state_q == ST_DONE);
   assign launch_hs_s      = launch_valid_i && launch_ready_o;
   assign cu_start_valid_o = grant_s;
   assign cu_start_pc_o    = PcWidth'(launch_q.pc);
   assign cu_start_gwid_o  = issued_q;
   assign num_warps_s      = KernelWarpWidth'(launch_q.num_warps);
   assign hs_s             = grant_valid_s && ((grant_s & cu_start_ready_i) != '0);
   assign done_eff_s       = (state_q != ST_IDLE) ? cu_warp_done_i : '0;
   assign issued_inc_s     = issued_q + KernelWarpWidth'(hs_s);
   assign retired_inc_s    = retired_q + retire_cnt_s;

   rr_credit_arbiter #(
      .NumPorts (NumComputeUnits),
      .IdxWidth (CuIdxWidth)
   ) u_arb (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .en_i          (state_q == ST_DISPATCH),
      .avail_i       (avail_s),
      .accept_i      (hs_s),
      .grant_valid_o (grant_valid_s),
      .grant_o       (grant_s),
      .grant_idx_o   (grant_idx_s)
   );

   // Per-CU credit bookkeeping and the retire popcount.
   always_comb begin
      retire_cnt_s = '0;
      for (int i = 0; i < int'(NumComputeUnits); i++) begin
         avail_s[i]      = (credit_q[i] != '0);
         credit_dec_s[i] = hs_s && (grant_idx_s == CuIdxWidth'(i));
         sat_s[i]        = (credit_q[i] == CreditWidth'(NumWarps)) && !credit_dec_s[i];
         // A done on a full CU is dropped so the credit never exceeds the slot count.
         credit_inc_s[i] = done_eff_s[i] && !sat_s[i];
         credit_d[i]     = credit_q[i] + CreditWidth'(credit_inc_s[i]) - CreditWidth'(credit_dec_s[i]);
         retire_cnt_s    = retire_cnt_s + KernelWarpWidth'(done_eff_s[i]);
      end
   end

   // Kernel FSM next-state.
   always_comb begin
      state_d   = state_q;
      launch_d  = launch_q;
      issued_d  = issued_q;
      retired_d = retired_q;
      case (state_q)
         ST_IDLE: begin
            if (launch_valid_i) begin
               launch_d.pc        = LaunchPcWidth'(launch_pc_i);
               launch_d.num_warps = LaunchWarpWidth'(launch_num_warps_i);
               issued_d           = '0;
               retired_d          = '0;
               state_d            = (launch_num_warps_i == '0) ? ST_DONE : ST_DISPATCH;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DISPATCH: begin
            issued_d  = issued_inc_s;
            retired_d = retired_inc_s;
            if (issued_inc_s == num_warps_s) begin
               state_d = (retired_inc_s == num_warps_s) ? ST_DONE : ST_DRAIN;
            end else begin
               state_d = ST_DISPATCH;
            end
         end
         ST_DRAIN: begin
            retired_d = retired_inc_s;
            if (retired_inc_s == num_warps_s) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         ST_DONE: begin
            retired_d = retired_inc_s;
            state_d   = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Kernel state, counters and credits.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         launch_q  <= '0;
         issued_q  <= '0;
         retired_q <= '0;
         for (int i = 0; i < int'(NumComputeUnits); i++) begin
            credit_q[i] <= CreditWidth'(NumWarps);
         end
      end else begin
         state_q   <= state_d;
         launch_q  <= launch_d;
         issued_q  <= issued_d;
         retired_q <= retired_d;
         for (int i = 0; i < int'(NumComputeUnits); i++) begin
            credit_q[i] <= credit_d[i];
         end
      end
   end

`ifdef BGPU_DISPATCH_PERF_EN
   logic [31:0] perf_q, perf_d;

   assign perf_cycles_o = perf_q;

   // Busy-cycle counter, saturating, held between kernels.
   always_comb begin
      if (launch_hs_s) begin
         perf_d = 32'd0;
      end else if (busy_o && (perf_q != 32'hFFFF_FFFF)) begin
         perf_d = perf_q + 32'd1;
      end else begin
         perf_d = perf_q;
      end
   end

   // Counter register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         perf_q <= 32'd0;
      end else begin
         perf_q <= perf_d;
      end
   end
`endif

   warp_launch_dispatcher_chk #(
      .NumComputeUnits (NumComputeUnits),
      .PcWidth         (PcWidth),
      .KernelWarpWidth (KernelWarpWidth)
   ) u_chk (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .idle_i  (launch_ready_o),
      .done_i  (cu_warp_done_i),
      .sat_i   (sat_s),
      .valid_i (cu_start_valid_o),
      .ready_i (cu_start_ready_i),
      .pc_i    (cu_start_pc_o),
      .gwid_i  (cu_start_gwid_o)
   );

endmodule

// File: tb/tb_warp_launch_dispatcher.sv
// Directed bench for warp_launch_dispatcher with 4 CUs and 2 warp slots per CU.
module tb_warp_launch_dispatcher;

   logic        clk = 1'b0;
   logic        rst;
   logic        launch_valid;
   logic        launch_ready;
   logic [15:0] launch_pc;
   logic [15:0] launch_num;
   logic        busy;
   logic        done;
   logic [3:0]  st_valid;
   logic [3:0]  st_ready;
   logic [15:0] st_pc;
   logic [15:0] st_gwid;
   logic [3:0]  warp_done;
`ifdef BGPU_DISPATCH_PERF_EN
   logic [31:0] perf;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   warp_launch_dispatcher #(
      .NumComputeUnits (4),
      .NumWarps        (2),
      .PcWidth         (16),
      .KernelWarpWidth (16)
   ) dut (
      .clk_i              (clk),
      .rst_i              (rst),
      .launch_valid_i     (launch_valid),
      .launch_ready_o     (launch_ready),
      .launch_pc_i        (launch_pc),
      .launch_num_warps_i (launch_num),
      .busy_o             (busy),
      .done_o             (done),
      .cu_start_valid_o   (st_valid),
      .cu_start_ready_i   (st_ready),
      .cu_start_pc_o      (st_pc),
      .cu_start_gwid_o    (st_gwid),
      .cu_warp_done_i     (warp_done)
`ifdef BGPU_DISPATCH_PERF_EN
      ,
      .perf_cycles_o      (perf)
`endif
   );

   typedef struct {
      logic [3:0]  ready;
      logic [3:0]  wdone;
      logic [3:0]  exp_valid;
      logic [15:0] exp_gwid;
      logic        exp_done;
      logic        exp_busy;
   } vec_t;

   vec_t vecs [14];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic launch(input logic [15:0] pc, input logic [15:0] n);
      launch_pc    = pc;
      launch_num   = n;
      launch_valid = 1'b1;
      tick();
      launch_valid = 1'b0;
   endtask

   task automatic expect_issue(input string name, input logic [3:0] cu, input logic [15:0] gwid);
      check({name, "_valid"}, 32'(st_valid), 32'(cu));
      check({name, "_gwid"}, 32'(st_gwid), 32'(gwid));
      tick();
   endtask

   initial begin
      int done_seen;
      rst          = 1'b1;
      launch_valid = 1'b0;
      launch_pc    = 16'h0000;
      launch_num   = 16'h0000;
      st_ready     = 4'hF;
      warp_done    = 4'h0;

      // 8 warps over 4 CUs, drain, then retire all 8 in two cycles
      for (int i = 0; i < 8; i++) begin
         vecs[i] = '{4'hF, 4'h0, 4'(1 << (i % 4)), 16'(i), 1'b0, 1'b1};
      end
      vecs[8]  = '{4'hF, 4'h0, 4'h0, 16'h0, 1'b0, 1'b1};
      vecs[9]  = '{4'hF, 4'h0, 4'h0, 16'h0, 1'b0, 1'b1};
      vecs[10] = '{4'hF, 4'hF, 4'h0, 16'h0, 1'b0, 1'b1};
      vecs[11] = '{4'hF, 4'hF, 4'h0, 16'h0, 1'b0, 1'b1};
      vecs[12] = '{4'hF, 4'h0, 4'h0, 16'h0, 1'b1, 1'b1};
      vecs[13] = '{4'hF, 4'h0, 4'h0, 16'h0, 1'b0, 1'b0};

      tick();
      tick();
      rst = 1'b0;
      check("rst_ready", 32'(launch_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_valid", 32'(st_valid), 32'd0);

      // Test A: table-driven
      launch(16'h1234, 16'd8);
      for (int i = 0; i < 14; i++) begin
         st_ready  = vecs[i].ready;
         warp_done = vecs[i].wdone;
         check($sformatf("A%0d_valid", i), 32'(st_valid), 32'(vecs[i].exp_valid));
         check($sformatf("A%0d_done", i), 32'(done), 32'(vecs[i].exp_done));
         check($sformatf("A%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
         if (vecs[i].exp_valid != 4'h0) begin
            check($sformatf("A%0d_gwid", i), 32'(st_gwid), 32'(vecs[i].exp_gwid));
            check($sformatf("A%0d_pc", i), 32'(st_pc), 32'h1234);
         end
         tick();
      end
      warp_done = 4'h0;
      check("A_ready_after", 32'(launch_ready), 32'd1);

      // Test B: credit stall, then returned credits steer the next warps
      launch(16'h2000, 16'd10);
      for (int i = 0; i < 8; i++) begin
         expect_issue("B_issue", 4'(1 << (i % 4)), 16'(i));
      end
      for (int i = 0; i < 3; i++) begin
         check("B_stall_valid", 32'(st_valid), 32'd0);
         check("B_stall_busy", 32'(busy), 32'd1);
         tick();
      end
      warp_done = 4'b0100;
      tick();
      warp_done = 4'b0000;
      expect_issue("B_cu2", 4'b0100, 16'd8);
      check("B_stall2_valid", 32'(st_valid), 32'd0);
      warp_done = 4'b0001;
      tick();
      warp_done = 4'b0000;
      expect_issue("B_cu0", 4'b0001, 16'd9);
      check("B_drain_valid", 32'(st_valid), 32'd0);
      warp_done = 4'hF;
      tick();
      tick();
      warp_done = 4'h0;
      check("B_done", 32'(done), 32'd1);
      tick();
      check("B_idle", 32'(launch_ready), 32'd1);

      // Test C: CU0 holds off for 5 cycles; a second launch request is ignored
      do_reset();
      st_ready = 4'b1110;
      launch(16'hBEEF, 16'd2);
      for (int i = 0; i < 5; i++) begin
         check("C_hold_valid", 32'(st_valid), 32'b0001);
         check("C_hold_pc", 32'(st_pc), 32'hBEEF);
         check("C_hold_gwid", 32'(st_gwid), 32'd0);
         launch_valid = (i == 1);
         launch_pc    = 16'h5555;
         launch_num   = 16'd7;
         tick();
      end
      launch_valid = 1'b0;
      st_ready = 4'hF;
      expect_issue("C_cu0", 4'b0001, 16'd0);
      check("C_pc_kept", 32'(st_pc), 32'hBEEF);
      expect_issue("C_cu1", 4'b0010, 16'd1);
      check("C_drain_valid", 32'(st_valid), 32'd0);
      warp_done = 4'b0011;
      tick();
      warp_done = 4'b0000;
      check("C_done", 32'(done), 32'd1);
      tick();

      // Test D: zero-warp kernel completes without any start request
      check("D_ready", 32'(launch_ready), 32'd1);
      launch(16'h0042, 16'd0);
      check("D_valid", 32'(st_valid), 32'd0);
      check("D_done", 32'(done), 32'd1);
      tick();
      check("D_done_clr", 32'(done), 32'd0);
      check("D_idle", 32'(launch_ready), 32'd1);

      // Test E: retire two CUs at once mid-dispatch (pointer continues at CU2)
      launch(16'h0300, 16'd4);
      expect_issue("E_w0", 4'b0100, 16'd0);
      expect_issue("E_w1", 4'b1000, 16'd1);
      expect_issue("E_w2", 4'b0001, 16'd2);
      st_ready  = 4'h0;
      warp_done = 4'b1100;
      check("E_w3_wait", 32'(st_valid), 32'b0010);
      tick();
      st_ready  = 4'hF;
      warp_done = 4'b0000;
      expect_issue("E_w3", 4'b0010, 16'd3);
      check("E_drain_done", 32'(done), 32'd0);
      warp_done = 4'b0011;
      tick();
      warp_done = 4'b0000;
      done_seen = 0;
      for (int i = 0; i < 4; i++) begin
         done_seen += int'(done);
         tick();
      end
      check("E_done_once", 32'(done_seen), 32'd1);

      // Reset in the middle of a second kernel
      launch(16'h0400, 16'd4);
      expect_issue("R_w0", 4'b0100, 16'd0);
      expect_issue("R_w1", 4'b1000, 16'd1);
      do_reset();
      check("R_ready", 32'(launch_ready), 32'd1);
      check("R_busy", 32'(busy), 32'd0);
      check("R_valid", 32'(st_valid), 32'd0);
      launch(16'h0500, 16'd8);
      for (int i = 0; i < 8; i++) begin
         expect_issue("R_full", 4'(1 << (i % 4)), 16'(i));
      end
      check("R_drain_valid", 32'(st_valid), 32'd0);
      warp_done = 4'hF;
      tick();
      tick();
      warp_done = 4'h0;
      check("R_done", 32'(done), 32'd1);
      tick();

`ifdef BGPU_DISPATCH_PERF_EN
      // Busy-cycle counter: launch at cycle 0, last retire at cycle 20
      do_reset();
      check("P_rst", perf, 32'd0);
      launch(16'h0600, 16'd4);
      for (int i = 0; i < 4; i++) begin
         expect_issue("P_issue", 4'(1 << i), 16'(i));
      end
      for (int i = 5; i < 20; i++) begin
         tick();
      end
      warp_done = 4'hF;
      tick();
      warp_done = 4'h0;
      check("P_done", 32'(done), 32'd1);
      tick();
      check("P_count", perf, 32'd21);
      tick();
      tick();
      check("P_hold", perf, 32'd21);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
